// File: rtl/fsm_run_controller.sv
// Initiator for the simple_fsm run handshake: issues one enable pulse per requested run,
// tracks IDLE->RUN->DONE->IDLE, counts completed runs and latches sticky errors.
module fsm_run_controller #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_runs,
   input  logic             clear,
   input  logic [1:0]       fsm_state,
   output logic             enable,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] runs_done,
   output logic             error,
   output logic [1:0]       err_code
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;
   localparam logic [1:0] S_ILL  = 2'b11;

   localparam logic [1:0] ERR_SEQ = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;
   localparam logic [1:0] ERR_ILL = 2'b11;

   typedef enum logic [2:0] {
      C_IDLE,
      C_ISSUE,
      C_WAIT_RUN,
      C_WAIT_DONE,
      C_WAIT_IDLE,
      C_FINISH,
      C_ERROR
   } state_e;

   state_e           state_q;
   logic             enable_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [1:0]       err_code_q;
   logic [CNT_W-1:0] runs_done_q;
   logic [CNT_W-1:0] target_q;
   logic [TW-1:0]    tmo_q;

   logic             adv;
   logic             viol;
   logic [CNT_W-1:0] runs_inc;
   logic             tmo_hit;

   assign runs_inc = runs_done_q + CNT_W'(1);
   assign tmo_hit  = (tmo_q == TMO_LAST);

   // Each wait state has one expected code to move on and one code that breaks the sequence.
   always_comb begin
      adv  = 1'b0;
      viol = 1'b0;
      case (state_q)
         C_WAIT_RUN: begin
            adv  = (fsm_state == S_RUN);
            viol = (fsm_state == S_DONE);
         end
         C_WAIT_DONE: begin
            adv  = (fsm_state == S_DONE);
            viol = (fsm_state == S_IDLE);
         end
         C_WAIT_IDLE: begin
            adv  = (fsm_state == S_IDLE);
            viol = (fsm_state == S_RUN);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= C_IDLE;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= '0;
         runs_done_q <= '0;
         target_q    <= '0;
         tmo_q       <= '0;
      end else begin
         enable_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            C_IDLE: begin
               if (start) begin
                  if (num_runs == '0) begin
                     runs_done_q <= '0;
                     done_q      <= 1'b1;
                     state_q     <= C_FINISH;
                  end else if (fsm_state == S_IDLE) begin
                     target_q    <= num_runs;
                     runs_done_q <= '0;
                     enable_q    <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= C_ISSUE;
                  end else begin
                     error_q    <= 1'b1;
                     err_code_q <= (fsm_state == S_ILL) ? ERR_ILL : ERR_SEQ;
                     state_q    <= C_ERROR;
                  end
               end
            end
            C_ISSUE, C_WAIT_RUN, C_WAIT_DONE, C_WAIT_IDLE: begin
               if (clear) begin
                  busy_q  <= 1'b0;
                  state_q <= C_IDLE;
               end else if (fsm_state == S_ILL) begin
                  busy_q     <= 1'b0;
                  error_q    <= 1'b1;
                  err_code_q <= ERR_ILL;
                  state_q    <= C_ERROR;
               end else if (state_q == C_ISSUE) begin
                  tmo_q   <= '0;
                  state_q <= C_WAIT_RUN;
               end else if (viol) begin
                  busy_q     <= 1'b0;
                  error_q    <= 1'b1;
                  err_code_q <= ERR_SEQ;
                  state_q    <= C_ERROR;
               end else if (adv) begin
                  tmo_q <= '0;
                  case (state_q)
                     C_WAIT_RUN:  state_q <= C_WAIT_DONE;
                     C_WAIT_DONE: state_q <= C_WAIT_IDLE;
                     default: begin
                        runs_done_q <= runs_inc;
                        if (runs_inc == target_q) begin
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                           state_q <= C_FINISH;
                        end else begin
                           enable_q <= 1'b1;
                           state_q  <= C_ISSUE;
                        end
                     end
                  endcase
               end else if (tmo_hit) begin
                  busy_q     <= 1'b0;
                  error_q    <= 1'b1;
                  err_code_q <= ERR_TMO;
                  state_q    <= C_ERROR;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            C_FINISH: begin
               state_q <= C_IDLE;
            end
            C_ERROR: begin
               if (clear) begin
                  error_q    <= 1'b0;
                  err_code_q <= '0;
                  state_q    <= C_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= C_IDLE;
            end
         endcase
      end
   end

   assign enable    = enable_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign runs_done = runs_done_q;
   assign error     = error_q;
   assign err_code  = err_code_q;

endmodule
